// File: rtl/fifo_pkg.sv
// Shared width constants for the async FIFO and its read-side packer.
package fifo_pkg;

  localparam int unsigned WORDSIZE_DEF = 8;
  localparam int unsigned ADDRSIZE_DEF = 4;

  // Width of a counter able to hold 0..pack.
  function automatic int unsigned cnt_width(input int unsigned pack);
    return int'($clog2(pack + 1));
  endfunction

endpackage

// File: rtl/out_reg_slice.sv
// One-entry valid/ready holding register for a packed word and its count.
module out_reg_slice #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 3
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [CW-1:0] load_cnt,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_cnt,
  output logic          out_valid,
  output logic          free_c
);

  // Free when empty or draining this cycle, so a drain and reload can coincide.
  assign free_c = !out_valid || out_ready;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_cnt   <= load_cnt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side drain of the async FIFO: packs PACK FIFO words into one wide
// valid/ready word, with a flush that emits a partially filled word.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned WORDSIZE = WORDSIZE_DEF,
  parameter int unsigned PACK     = 4,
  parameter int unsigned CNTW     = cnt_width(PACK)
) (
  input  logic                     rclk,
  input  logic                     rst,
  input  logic [WORDSIZE-1:0]      fifo_rdata,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  input  logic                     flush,
  output logic [WORDSIZE*PACK-1:0] out_data,
  output logic [CNTW-1:0]          out_cnt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int unsigned IDXW = $clog2(PACK);
  localparam int unsigned ACCW = (PACK - 1) * WORDSIZE;
  localparam int unsigned DW   = WORDSIZE * PACK;

  logic [IDXW-1:0] idx, idx_nxt;
  logic [ACCW-1:0] acc, acc_nxt;
  logic            flush_pend, flush_pend_nxt;
  logic            out_free, last, pop, load, valid_nxt;
  logic [DW-1:0]   load_data;
  logic [CNTW-1:0] load_cnt;

  assign last = (idx == IDXW'(PACK - 1));
  // Pop gated by reset so the FIFO never loses a word while we are held in reset.
  assign pop     = !rst && !fifo_empty && !flush_pend && !(last && !out_free);
  assign fifo_rd = pop;

  always_comb begin
    idx_nxt        = idx;
    acc_nxt        = acc;
    flush_pend_nxt = flush_pend;
    load           = 1'b0;
    load_data      = '0;
    load_cnt       = '0;
    if (flush_pend) begin
      if (out_free) begin
        load           = 1'b1;
        load_data      = {{WORDSIZE{1'b0}}, acc};
        load_cnt       = CNTW'(idx);
        idx_nxt        = '0;
        acc_nxt        = '0;
        flush_pend_nxt = 1'b0;
      end
    end else begin
      if (pop) begin
        if (last) begin
          load      = 1'b1;
          load_data = {fifo_rdata, acc};
          load_cnt  = CNTW'(PACK);
          idx_nxt   = '0;
          acc_nxt   = '0;
        end else begin
          for (int unsigned i = 0; i < PACK - 1; i++) begin
            if (idx == IDXW'(i)) acc_nxt[i*WORDSIZE +: WORDSIZE] = fifo_rdata;
          end
          idx_nxt = idx + IDXW'(1);
        end
      end
      // Flush sees the index after this cycle's pop; a just-completed word leaves nothing.
      if (flush && (idx_nxt != '0)) flush_pend_nxt = 1'b1;
    end
  end

  assign valid_nxt = load || (out_valid && !out_ready);

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
      busy       <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      acc        <= acc_nxt;
      flush_pend <= flush_pend_nxt;
      busy       <= (idx_nxt != '0) || valid_nxt || flush_pend_nxt;
    end
  end

  out_reg_slice #(
    .DW (DW),
    .CW (CNTW)
  ) u_out (
    .rclk      (rclk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .free_c    (out_free)
  );

endmodule
